// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// The master side issues requests and observes the memory writes.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [25:0]       in_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into MIPS words and writes them sequentially
// into instruction memory, one registered write per accepted request.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   instr_encoder_if.slave    bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LastAddr = '1;
   localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

   localparam logic [3:0] KAdd  = 4'd0;
   localparam logic [3:0] KSub  = 4'd1;
   localparam logic [3:0] KAnd  = 4'd2;
   localparam logic [3:0] KOr   = 4'd3;
   localparam logic [3:0] KSlt  = 4'd4;
   localparam logic [3:0] KAddi = 4'd5;
   localparam logic [3:0] KLw   = 4'd6;
   localparam logic [3:0] KSw   = 4'd7;
   localparam logic [3:0] KBeq  = 4'd8;
   localparam logic [3:0] KJ    = 4'd9;
   localparam logic [3:0] KNop  = 4'd10;
   localparam logic [3:0] KEnd  = 4'd11;

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic        in_ready;
   logic        accept;
   logic        encodable;
   logic [31:0] word;

   // Instruction packing; kinds 11 (END) and 12-15 produce no word.
   always_comb begin
      word      = '0;
      encodable = 1'b1;
      case (bus.in_kind)
         KAdd:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h20};
         KSub:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h22};
         KAnd:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h24};
         KOr:   word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h25};
         KSlt:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h2A};
         KAddi: word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
         KLw:   word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
         KSw:   word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
         KBeq:  word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
         KJ:    word = {6'h02, bus.in_imm};
         KNop:  word = 32'h0000_0000;
         default: encodable = 1'b0;
      endcase
   end

   assign in_ready = (state_q == StLoad) && !start;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (start) begin
         // An in-flight write (we_q) still completes this cycle with its old address.
         state_d = StLoad;
         ptr_d   = BaseAddr;
         count_d = '0;
      end else if (accept) begin
         if (encodable) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            count_d = count_q + CountOne;
            // Filling the last location ends the load; the pointer never wraps.
            if (ptr_q == LastAddr) begin
               state_d = StDone;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end else if (bus.in_kind == KEnd) begin
            state_d = StDone;
         end else begin
            state_d = StErr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= BaseAddr;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= BaseAddr;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

   // done/err are sticky because only start leaves DONE/ERR.
   assign busy  = (state_q == StLoad);
   assign done  = (state_q == StDone);
   assign err   = (state_q == StErr);
   assign count = count_q;

endmodule
